dsam_decoder: RTL and testbench
===============================

Name: dsam_decoder

Overview:
- Downstream counterpart of the DSAM encoder; restores original samples from the DSAM-encoded stream for CHANNELS interleaved channels.
- Undoes the XOR correlation to recover the per-channel difference, then adds the sample from the same channel one frame earlier.
- Sits on the receive/readback side, directly consuming encoder output words.
- Valid/ready handshake on both sides; 2-stage pipeline.

Parameters:
- DATA_WIDTH, 16: sample/word width W, in bits (≥2).
- CHANNELS, 256: interleaved channels C, which is also the frame length (≥2).
- CH_WIDTH, $clog2(CHANNELS): channel counter width.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge).
- in_valid  in  1  encoded word present.
- in_ready  out  1  decoder can accept this cycle.
- in  in  DATA_WIDTH  encoded word e_n = {s_n, c_n}.
- out_valid  out  1  decoded sample present.
- out_ready  in  1  sink accepts.
- out  out  DATA_WIDTH  decoded sample x_n.
- channel  out  CH_WIDTH  channel index of the sample on out (n mod C).

Behaviour:
- Encoding definition (decoder contract):
  - d_n = x_n for n<C; otherwise d_n = x_n − x_{n−C} mod 2^W.
  - s_n = d_n[W−1]; c_n = c_{n−1} ^ d_n[W−2:0], with c_{−1} = 0.
- Stage 1, decorrelate (on accept):
  - d = {in[W−1], in[W−2:0] ^ corr_prev}.
  - corr_prev <= in[W−2:0].
  - Latch d and the current channel count ch; ch then advances mod C (C−1 wraps to 0).
- Stage 2, reconstruct:
  - warm==0: x = d.
  - warm==1: x = d + hist[ch] mod 2^W (carry dropped).
  - hist is a C×W array read combinationally at ch, so there is no read/write hazard.
  - On stage-2 advance: hist[ch] <= x. When the C−1 sample leaves stage 2 while warm==0, warm <= 1.
- Handshake:
  - adv = !out_valid || out_ready; in_ready = adv.
  - Both stages move together only when adv==1. Accept = in_valid && in_ready.
  - Latency: 2 cycles from accept to out_valid, with no backpressure.
  - Throughput: 1 word/cycle.
  - While out_valid && !out_ready: out, channel, stage 1, corr_prev and ch all hold stable.
  - Bubbles (in_valid==0 while adv==1) propagate; they do not advance ch and do not change corr_prev or hist.
- Reset (also mid-operation, with priority over any transfer):
  - out_valid=0, stage-1 valid=0, out=0, channel=0.
  - ch=0, corr_prev=0, warm=0.
  - hist contents are don't-care, because warm=0 masks them.
  - The first word after reset is treated as n=0.
- Simultaneous accept and output in the same cycle is legal and sustains full rate.

Optional Feature:
- Macro: DSAM_DEC_BYPASS_EN.
- Defined: adds input port bypass (1 bit), sampled at accept and carried with the word.
  - A bypassed word emerges unchanged on out, with the same latency and handshake.
  - It does not advance ch and does not touch corr_prev or hist.
- Undefined: no bypass port; every word is decoded.

Test Plan:
- Warm-up and steady state, C=4, W=16, no backpressure:
  - Feed 0x0064, 0x00AC, 0x0180, 0x0010, 0x001A, 0xFFEC.
  - Expect out 100, 200, 300, 400, 110, 190, with channel 0, 1, 2, 3, 0, 1.
  - Expect out_valid exactly 2 cycles after each accept.
- Backpressure:
  - Same stream, with out_ready low for 3 cycles while out=300.
  - Expect out held at 300, in_ready=0, no word lost or duplicated, and the rest of the sequence unchanged.
- Bubbles:
  - Insert in_valid=0 gaps between every word of the first test.
  - Expect identical outputs and channel tags.
- Wrap-around arithmetic:
  - C=2. Samples 0xFFFF, 0x0001, then 0x0003, 0x0000, with the encoded stream computed from the encoding definition.
  - Expect out 0xFFFF, 0x0001, 0x0003, 0x0000; 0x0003 checks the dropped carry.
- Mid-stream reset:
  - reset low for 1 cycle after 5 words of the first test.
  - Expect out_valid=0 next cycle. Refeeding 0x0064, 0x00AC yields 100, 200 on channels 0, 1, so warm was cleared.
- Random regression:
  - 10k random samples, C=8, through a reference encoder model, with random in_valid/out_ready.
  - Expect bit-exact reconstruction.

Source files
------------

// File: rtl/dsam_decoder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// dsam_decoder
//
// Restores the original samples from a DSAM-encoded word stream that carries
// CHANNELS interleaved channels. Stage 1 undoes the running XOR correlation
// to recover the per-channel difference. Stage 2 adds the sample that the
// same channel carried one frame earlier, which is kept in a per-channel
// history table.
//
// Both sides use a valid/ready handshake. The two pipeline stages only move
// together, so a stalled output freezes the whole decoder.
//
// Ports:
//   clk        clock, every register updates on the rising edge
//   reset      synchronous, active-low reset
//   in_valid   an encoded word is present on 'in'
//   in_ready   the decoder accepts a word this cycle
//   in         encoded word {sign, correlated low bits}
//   out_valid  a decoded sample is present on 'out'
//   out_ready  the sink accepts the sample this cycle
//   out        decoded sample
//   channel    channel index of the sample on 'out'
//   bypass     (only with DSAM_DEC_BYPASS_EN) passes the word through untouched
//
// Optional feature macro: DSAM_DEC_BYPASS_EN adds the 'bypass' input. A
// bypassed word keeps the normal latency and handshake, but it leaves the
// channel counter, the correlation register and the history table alone.
// ---------------------------------------------------------------------------
module dsam_decoder #(
   parameter int DATA_WIDTH = 16,
   parameter int CHANNELS   = 256,
   parameter int CH_WIDTH   = $clog2(CHANNELS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in,
`ifdef DSAM_DEC_BYPASS_EN
   input  logic                  bypass,
`endif
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out,
   output logic [CH_WIDTH-1:0]   channel
);

   localparam int W = DATA_WIDTH;
   localparam logic [CH_WIDTH-1:0] LAST_CH = CH_WIDTH'(CHANNELS - 1);

   logic                s1Valid_q, s1Valid_d;
   logic [W-1:0]        s1Data_q, s1Data_d;
   logic [CH_WIDTH-1:0] s1Ch_q, s1Ch_d;
   logic                s1Byp_q, s1Byp_d;
   logic [W-2:0]        corrPrev_q, corrPrev_d;
   logic [CH_WIDTH-1:0] ch_q, ch_d;
   logic                outValid_q, outValid_d;
   logic [W-1:0]        out_q, out_d;
   logic [CH_WIDTH-1:0] outCh_q, outCh_d;
   logic                warm_q, warm_d;
   logic [W-1:0]        hist_q [CHANNELS];

   logic                adv;
   logic                accept;
   logic                inBypass;
   logic                histWe;
   logic [W-1:0]        recon;

`ifdef DSAM_DEC_BYPASS_EN
   assign inBypass = bypass;
`else
   assign inBypass = 1'b0;
`endif

   // Both stages advance together whenever the output register is free or is
   // being drained this cycle, so that is also when a new word is accepted.
   assign adv      = !outValid_q || out_ready;
   assign accept   = in_valid && adv;
   assign in_ready = adv;

   // Until every channel has produced one sample there is no previous frame,
   // so the history table is ignored while warm is clear.
   always_comb begin
      recon = s1Data_q;
      if (!s1Byp_q && warm_q) begin
         recon = s1Data_q + hist_q[s1Ch_q];
      end
   end

   // Next-state logic for both pipeline stages. Bubbles empty the stages but
   // leave the channel counter, the correlation register and the history alone.
   always_comb begin
      s1Valid_d  = s1Valid_q;
      s1Data_d   = s1Data_q;
      s1Ch_d     = s1Ch_q;
      s1Byp_d    = s1Byp_q;
      corrPrev_d = corrPrev_q;
      ch_d       = ch_q;
      outValid_d = outValid_q;
      out_d      = out_q;
      outCh_d    = outCh_q;
      warm_d     = warm_q;
      histWe     = 1'b0;
      if (adv) begin
         s1Valid_d = in_valid;
         if (accept) begin
            s1Byp_d = inBypass;
            s1Ch_d  = ch_q;
            if (inBypass) begin
               s1Data_d = in;
            end else begin
               s1Data_d   = {in[W-1], in[W-2:0] ^ corrPrev_q};
               corrPrev_d = in[W-2:0];
               ch_d       = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
            end
         end
         outValid_d = s1Valid_q;
         if (s1Valid_q) begin
            out_d   = recon;
            outCh_d = s1Ch_q;
            if (!s1Byp_q) begin
               histWe = 1'b1;
               if (s1Ch_q == LAST_CH) begin
                  warm_d = 1'b1;
               end
            end
         end
      end
   end

   // Pipeline and control registers; reset wins over any transfer that would
   // otherwise happen on the same edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1Valid_q  <= 1'b0;
         s1Data_q   <= '0;
         s1Ch_q     <= '0;
         s1Byp_q    <= 1'b0;
         corrPrev_q <= '0;
         ch_q       <= '0;
         outValid_q <= 1'b0;
         out_q      <= '0;
         outCh_q    <= '0;
         warm_q     <= 1'b0;
      end else begin
         s1Valid_q  <= s1Valid_d;
         s1Data_q   <= s1Data_d;
         s1Ch_q     <= s1Ch_d;
         s1Byp_q    <= s1Byp_d;
         corrPrev_q <= corrPrev_d;
         ch_q       <= ch_d;
         outValid_q <= outValid_d;
         out_q      <= out_d;
         outCh_q    <= outCh_d;
         warm_q     <= warm_d;
      end
   end

   // History table: one word per channel, holding the last reconstructed
   // sample. It has no reset because warm masks its contents after reset.
   always_ff @(posedge clk) begin
      if (reset && histWe) begin
         hist_q[s1Ch_q] <= recon;
      end
   end

   assign out_valid = outValid_q;
   assign out       = out_q;
   assign channel   = outCh_q;

endmodule

// File: tb/tb_dsam_decoder.sv
`timescale 1ns/1ps
// Bench for dsam_decoder. Three decoder instances (4, 2 and 8 channels) share
// one stimulus bus; 'sel' routes the bus to one of them at a time. The
// stimulus side pushes the expected sample into a queue when a word is
// accepted. A monitor pops the queue whenever the selected decoder hands over
// an output.
module tb_dsam_decoder;

   typedef struct {
      logic [15:0] data;
      int          ch;
      int          accCyc;
      bit          chkLat;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetN;
   logic        inValid;
   logic [15:0] inData;
   logic        outReady;
   int          sel;

   logic [2:0]  instInReady;
   logic [2:0]  instOutValid;
   logic [15:0] instOut [3];
   logic [1:0]  ch4;
   logic [0:0]  ch2;
   logic [2:0]  ch8;

   logic        inReady;
   logic        outValid;
   logic [15:0] outData;
   int          outCh;

   exp_t        expQ[$];
   int          nVec = 0;
   int          nMiss = 0;
   int          cyc = 0;

   logic [15:0] enc1 [6] = '{16'h0064, 16'h00AC, 16'h0180, 16'h0010, 16'h001A, 16'hFFEC};
   logic [15:0] dec1 [6] = '{16'd100, 16'd200, 16'd300, 16'd400, 16'd110, 16'd190};
   logic [15:0] enc2 [4] = '{16'hFFFF, 16'h7FFE, 16'h7FFA, 16'h8005};
   logic [15:0] dec2 [4] = '{16'hFFFF, 16'h0001, 16'h0003, 16'h0000};

   bit          randDone;
   logic [15:0] prevX [8];
   logic [14:0] cPrev;

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   dsam_decoder #(.DATA_WIDTH(16), .CHANNELS(4)) dut4 (
      .clk(clk), .reset(resetN),
      .in_valid(inValid && sel == 0), .in_ready(instInReady[0]), .in(inData),
`ifdef DSAM_DEC_BYPASS_EN
      .bypass(1'b0),
`endif
      .out_valid(instOutValid[0]), .out_ready(sel == 0 ? outReady : 1'b1),
      .out(instOut[0]), .channel(ch4)
   );

   dsam_decoder #(.DATA_WIDTH(16), .CHANNELS(2)) dut2 (
      .clk(clk), .reset(resetN),
      .in_valid(inValid && sel == 1), .in_ready(instInReady[1]), .in(inData),
`ifdef DSAM_DEC_BYPASS_EN
      .bypass(1'b0),
`endif
      .out_valid(instOutValid[1]), .out_ready(sel == 1 ? outReady : 1'b1),
      .out(instOut[1]), .channel(ch2)
   );

   dsam_decoder #(.DATA_WIDTH(16), .CHANNELS(8)) dut8 (
      .clk(clk), .reset(resetN),
      .in_valid(inValid && sel == 2), .in_ready(instInReady[2]), .in(inData),
`ifdef DSAM_DEC_BYPASS_EN
      .bypass(1'b0),
`endif
      .out_valid(instOutValid[2]), .out_ready(sel == 2 ? outReady : 1'b1),
      .out(instOut[2]), .channel(ch8)
   );

   // Route the selected instance onto the common observation signals.
   always_comb begin
      inReady  = instInReady[0];
      outValid = instOutValid[0];
      outData  = instOut[0];
      outCh    = int'(ch4);
      case (sel)
         1: begin
            inReady  = instInReady[1];
            outValid = instOutValid[1];
            outData  = instOut[1];
            outCh    = int'(ch2);
         end
         2: begin
            inReady  = instInReady[2];
            outValid = instOutValid[2];
            outData  = instOut[2];
            outCh    = int'(ch8);
         end
         default: ;
      endcase
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      nVec++;
      if (got !== want) begin
         nMiss++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Drive one word and wait until it is accepted; the expected sample is
   // queued as soon as the handshake is seen.
   task automatic applyStimulus(input logic [15:0] word, input logic [15:0] expData,
                                input int expCh, input bit lat);
      int   waitCyc;
      exp_t e;
      waitCyc = 0;
      inValid = 1'b1;
      inData  = word;
      @(negedge clk);
      while (!inReady && waitCyc < 50) begin
         waitCyc++;
         @(negedge clk);
      end
      if (!inReady) begin
         nVec++;
         nMiss++;
         $display("[TB] FAIL accept_timeout: word %0h not accepted within 50 cycles", word);
      end else begin
         e.data   = expData;
         e.ch     = expCh;
         e.accCyc = cyc;
         e.chkLat = lat;
         expQ.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycle();
      inValid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      inValid  = 1'b0;
      outReady = 1'b1;
      resetN   = 1'b0;
      @(posedge clk);
      #1;
      resetN = 1'b1;
      expQ.delete();
   endtask

   task automatic waitDrain(input string name);
      int k;
      k = 0;
      inValid = 1'b0;
      while (expQ.size() != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      checkOutput(name, expQ.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: every output handshake outside reset consumes one expected entry.
   always @(negedge clk) begin
      exp_t e;
      if (resetN && outValid && outReady) begin
         if (expQ.size() == 0) begin
            nVec++;
            nMiss++;
            $display("[TB] FAIL unexpected_output: got %0h on channel %0d, expected nothing", outData, outCh);
         end else begin
            e = expQ.pop_front();
            checkOutput("out_data", outData, e.data);
            checkOutput("out_channel", outCh, e.ch);
            if (e.chkLat) begin
               checkOutput("latency", cyc - e.accCyc, 2);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [15:0] x;
      logic [15:0] d;
      logic [15:0] e;
      resetN   = 1'b0;
      inValid  = 1'b0;
      inData   = '0;
      outReady = 1'b1;
      sel      = 0;
      randDone = 1'b0;

      // Reset state
      doReset();
      @(negedge clk);
      checkOutput("rst_out_valid", outValid, 0);
      checkOutput("rst_in_ready", inReady, 1);
      checkOutput("rst_out", outData, 0);
      checkOutput("rst_channel", outCh, 0);
      @(posedge clk);
      #1;

      // Warm-up and steady state, back to back, latency checked
      $display("[TB] warm-up and steady state");
      doReset();
      for (int i = 0; i < 6; i++) applyStimulus(enc1[i], dec1[i], i % 4, 1'b1);
      waitDrain("drain_steady");

      // Backpressure while 300 is on the output
      $display("[TB] backpressure");
      doReset();
      fork
         begin
            for (int i = 0; i < 6; i++) applyStimulus(enc1[i], dec1[i], i % 4, 1'b0);
            inValid = 1'b0;
         end
         begin
            int  k;
            bit  seen;
            k    = 0;
            seen = 1'b0;
            while (!seen && k < 100) begin
               @(posedge clk);
               #1;
               k++;
               if (outValid && outData == 16'd300) seen = 1'b1;
            end
            checkOutput("bp_seen_300", seen, 1);
            outReady = 1'b0;
            repeat (3) begin
               @(negedge clk);
               checkOutput("bp_hold_out", outData, 16'd300);
               checkOutput("bp_hold_valid", outValid, 1);
               checkOutput("bp_in_ready", inReady, 0);
            end
            @(posedge clk);
            #1;
            outReady = 1'b1;
         end
      join
      waitDrain("drain_backpressure");

      // Bubbles between every word
      $display("[TB] bubbles");
      doReset();
      for (int i = 0; i < 6; i++) begin
         applyStimulus(enc1[i], dec1[i], i % 4, 1'b1);
         idleCycle();
      end
      waitDrain("drain_bubbles");

      // Wrap-around arithmetic on the two-channel decoder
      $display("[TB] wrap-around");
      sel = 1;
      doReset();
      for (int i = 0; i < 4; i++) applyStimulus(enc2[i], dec2[i], i % 2, 1'b1);
      waitDrain("drain_wrap");

      // Mid-stream reset clears the pipeline and the warm flag
      $display("[TB] mid-stream reset");
      sel = 0;
      doReset();
      for (int i = 0; i < 5; i++) applyStimulus(enc1[i], dec1[i], i % 4, 1'b0);
      inValid = 1'b0;
      resetN  = 1'b0;
      @(posedge clk);
      #1;
      resetN = 1'b1;
      expQ.delete();
      @(negedge clk);
      checkOutput("midrst_out_valid", outValid, 0);
      checkOutput("midrst_out", outData, 0);
      checkOutput("midrst_channel", outCh, 0);
      @(posedge clk);
      #1;
      applyStimulus(16'h0064, 16'd100, 0, 1'b1);
      applyStimulus(16'h00AC, 16'd200, 1, 1'b1);
      waitDrain("drain_midreset");

      // Random regression on the eight-channel decoder through a reference encoder
      $display("[TB] random regression");
      sel = 2;
      doReset();
      cPrev = '0;
      fork
         begin
            for (int n = 0; n < 10000; n++) begin
               x = 16'($urandom);
               d = (n < 8) ? x : x - prevX[n % 8];
               e = {d[15], cPrev ^ d[14:0]};
               cPrev = e[14:0];
               prevX[n % 8] = x;
               if ($urandom_range(0, 3) == 0) idleCycle();
               applyStimulus(e, x, n % 8, 1'b0);
            end
            inValid  = 1'b0;
            randDone = 1'b1;
         end
         begin
            while (!randDone) begin
               @(posedge clk);
               #1;
               outReady = ($urandom_range(0, 3) != 0);
            end
            outReady = 1'b1;
         end
      join
      waitDrain("drain_random");

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
      $finish;
   end

endmodule
